tick_generator: RTL and testbench

TICK_GENERATOR -- requirements
Module: tick_generator

---
 rtl/tick_generator.sv | 136 +++++++++++++
 tb/tb_tick_generator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_generator.sv
// Purpose : multi-channel programmable tick generator; each channel emits a
//           one-cycle pulse every max(div,1) cycles (periodic) or once (one-shot).
// Latency : first tick one edge after a channel is enabled; tick/active registered.
// Backpressure: none; cfg writes and sync are accepted on every rising edge.
//
// Ports:
//   clk          - core clock, all state changes on its rising edge
//   clr          - asynchronous active-low reset
//   cfg_we       - configuration write strobe (ignored when cfg_chan is out of range)
//   cfg_chan     - channel index for the write
//   cfg_div      - new divisor (0 behaves as 1)
//   cfg_oneshot  - 1 = one-shot, 0 = periodic
//   cfg_en       - new enable value for the addressed channel
//   sync         - restart every enabled channel so they tick together next edge
//   tick         - per-channel registered one-cycle pulse
//   active       - per-channel registered enable
module tick_generator #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_oneshot,
    input  logic                cfg_en,
    input  logic                sync,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] active
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [CW:0]      CH_LIM  = (CW + 1)'(CHANNELS);

    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    div_q    [CHANNELS];
    logic [WIDTH-1:0]    div_d    [CHANNELS];
    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [WIDTH-1:0]    cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] en_q,   en_d;
    logic [CHANNELS-1:0] mode_q, mode_d;   // 1 = one-shot
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] cfg_hit;
    logic                cfg_ok;

    // Reload value for the down-counter: max(d,1)-1, so div 0 and 1 both tick every cycle.
    function automatic logic [WIDTH-1:0] reload_val(input logic [WIDTH-1:0] d);
        return (d == '0) ? '0 : d - WIDTH'(1);
    endfunction

    // Out-of-range channel indices (possible when CHANNELS is not a power of 2) are dropped.
    assign cfg_ok = ({1'b0, cfg_chan} < CH_LIM);

    always_comb begin
        cfg_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cfg_hit[i] = cfg_we && cfg_ok && (cfg_chan == CW'(i));
        end
    end

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        tick_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            div_d[i]    = div_q[i];
            cnt_d[i]    = cnt_q[i];

            // The write is applied first; sync and counting see its result.
            if (cfg_hit[i]) begin
                shadow_d[i] = cfg_div;
                mode_d[i]   = cfg_oneshot;
                en_d[i]     = cfg_en;
                // An idle channel has no period in flight, so the divisor is live at once.
                if (!en_q[i]) begin
                    div_d[i] = cfg_div;
                end
            end

            if (sync) begin
                // Counter parked at 0 so every enabled channel ticks on the next edge.
                cnt_d[i] = '0;
                if (en_d[i]) begin
                    div_d[i] = shadow_d[i];
                end
            end else if (en_q[i] && en_d[i]) begin
                // Counting uses the registered enable, so a freshly enabled channel
                // ticks one edge after the write; a write with cfg_en=0 stops it at once.
                if (cnt_q[i] == '0) begin
                    tick_d[i] = 1'b1;
                    cnt_d[i]  = reload_val(shadow_q[i]);
                    div_d[i]  = shadow_q[i];
                    // A same-edge write owns the enable, so it can re-arm a one-shot.
                    if (mode_q[i] && !cfg_hit[i]) begin
                        en_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - WIDTH'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            en_q   <= '0;
            mode_q <= '0;
            tick_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= DEF_DIV;
                div_q[i]    <= DEF_DIV;
                cnt_q[i]    <= '0;
            end
        end else begin
            en_q   <= en_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                div_q[i]    <= div_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign tick   = tick_q;
    assign active = en_q;

endmodule

// File: tb/tb_tick_generator.sv
// Directed table-driven bench for tick_generator with CHANNELS=3 (non power of 2).
module tb_tick_generator;

    localparam int CH = 3;
    localparam int W  = 8;

    logic          clk;
    logic          clr;
    logic          cfg_we;
    logic [1:0]    cfg_chan;
    logic [W-1:0]  cfg_div;
    logic          cfg_oneshot;
    logic          cfg_en;
    logic          sync;
    logic [CH-1:0] tick;
    logic [CH-1:0] active;

    int errors = 0;
    int checks = 0;

    tick_generator #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_DIV (1)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .cfg_we      (cfg_we),
        .cfg_chan    (cfg_chan),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .cfg_en      (cfg_en),
        .sync        (sync),
        .tick        (tick),
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [1:0]    ch;
        logic [W-1:0]  dv;
        logic          os;
        logic          en;
        logic          sy;
        logic [CH-1:0] etick;
        logic [CH-1:0] eact;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic we, input logic [1:0] ch, input logic [W-1:0] dv,
                       input logic os, input logic en, input logic sy,
                       input logic [CH-1:0] et, input logic [CH-1:0] ea);
        vec_t v;
        v.we = we; v.ch = ch; v.dv = dv; v.os = os; v.en = en; v.sy = sy;
        v.etick = et; v.eact = ea;
        vq.push_back(v);
    endtask

    task automatic idle(input logic [CH-1:0] et, input logic [CH-1:0] ea);
        add(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, et, ea);
    endtask

    task automatic drive(input logic we, input logic [1:0] ch, input logic [W-1:0] dv,
                         input logic os, input logic en, input logic sy);
        cfg_we = we; cfg_chan = ch; cfg_div = dv; cfg_oneshot = os; cfg_en = en; sync = sy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH-1:0] exp_sync [6];
        bit found;

        // ---------------- reset ----------------
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("reset tick", tick, 3'b000);
        check("reset active", active, 3'b000);
        clr = 1'b1;

        // ---------------- vector table ----------------
        idle(3'b000, 3'b000);                                       // 0
        add(1'b1, 2'd0, 8'd5, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001);    // 1 ch0 div5
        idle(3'b001, 3'b001);                                       // 2 first tick
        idle(3'b000, 3'b001);                                       // 3
        idle(3'b000, 3'b001);                                       // 4
        idle(3'b000, 3'b001);                                       // 5
        idle(3'b000, 3'b001);                                       // 6
        idle(3'b001, 3'b001);                                       // 7 5 cycles later
        add(1'b1, 2'd1, 8'd0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b011);    // 8 ch1 div0
        idle(3'b010, 3'b011);                                       // 9
        idle(3'b010, 3'b011);                                       // 10
        add(1'b1, 2'd1, 8'd3, 1'b0, 1'b1, 1'b0, 3'b010, 3'b011);    // 11 ch1 div3
        idle(3'b011, 3'b011);                                       // 12 boundary
        idle(3'b000, 3'b011);                                       // 13
        idle(3'b000, 3'b011);                                       // 14
        idle(3'b010, 3'b011);                                       // 15
        idle(3'b000, 3'b011);                                       // 16
        idle(3'b001, 3'b011);                                       // 17
        idle(3'b010, 3'b011);                                       // 18
        add(1'b1, 2'd3, 8'd9, 1'b1, 1'b0, 1'b0, 3'b000, 3'b011);    // 19 chan 3 invalid
        idle(3'b000, 3'b011);                                       // 20
        idle(3'b010, 3'b011);                                       // 21
        idle(3'b001, 3'b011);                                       // 22
        add(1'b1, 2'd0, 8'd5, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010);    // 23 disable ch0
        add(1'b1, 2'd1, 8'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);    // 24 disable ch1
        add(1'b1, 2'd2, 8'd4, 1'b1, 1'b1, 1'b0, 3'b000, 3'b100);    // 25 ch2 one-shot
        idle(3'b100, 3'b000);                                       // 26 single tick
        idle(3'b000, 3'b000);                                       // 27

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].we, vq[i].ch, vq[i].dv, vq[i].os, vq[i].en, vq[i].sy);
            step();
            check($sformatf("vec%0d tick", i), tick, vq[i].etick);
            check($sformatf("vec%0d active", i), active, vq[i].eact);
        end
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        // one-shot stays silent afterwards
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("oneshot quiet%0d", i), tick, 3'b000);
        end

        // ---------------- sync (with same-edge enable of ch2) ----------------
        drive(1'b1, 2'd0, 8'd3, 1'b0, 1'b1, 1'b0); step();
        drive(1'b1, 2'd1, 8'd7, 1'b0, 1'b1, 1'b0); step();
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        exp_sync[0] = 3'b000;
        exp_sync[1] = 3'b111;
        exp_sync[2] = 3'b000;
        exp_sync[3] = 3'b100;
        exp_sync[4] = 3'b001;
        exp_sync[5] = 3'b100;
        drive(1'b1, 2'd2, 8'd2, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
            check($sformatf("sync+%0d tick", i), tick, exp_sync[i]);
        end
        check("sync active", active, 3'b111);

        // ---------------- async reset mid-period ----------------
        drive(1'b1, 2'd0, 8'd10, 1'b0, 1'b1, 1'b0); step();
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (tick[0] === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL ch0 div10 tick wait: got none expected a tick within 40 cycles");
        end
        #2;
        clr = 1'b0;
        #1;
        check("async clr tick", tick, 3'b000);
        check("async clr active", active, 3'b000);
        repeat (2) @(posedge clk);
        #3;
        clr = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            check($sformatf("post-clr quiet%0d", i), tick | active, 3'b000);
        end
        drive(1'b1, 2'd0, 8'd10, 1'b0, 1'b1, 1'b0); step();
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check("re-enable tick", tick, 3'b000);
        check("re-enable active", active, 3'b001);
        step();
        check("re-enable first tick", tick, 3'b001);

        // ---------------- one-shot re-armed by same-edge write ----------------
        drive(1'b1, 2'd2, 8'd3, 1'b1, 1'b1, 1'b0); step();
        check("rearm arm tick2", {2'b00, tick[2]}, 3'b000);
        step();
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check("rearm edge tick2", {2'b00, tick[2]}, 3'b001);
        check("rearm edge active2", {2'b00, active[2]}, 3'b001);
        step();
        step();
        check("rearm mid tick2", {2'b00, tick[2]}, 3'b000);
        step();
        check("rearm final tick2", {2'b00, tick[2]}, 3'b001);
        check("rearm final active2", {2'b00, active[2]}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
